// File: rtl/fx2_slave_fifo_model.sv
// Cypress FX2 slave-FIFO device model: EP2 (host->FPGA, FWFT) and EP6
// (FPGA->host, with packet-end tagging) behind the FX2 synchronous bus.
//
// Build option: define FX2_MODEL_FLAG_LATENCY_EN to delay all four flags by
// one register stage, like the real chip.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   fx2_slcs_n/slwr_n/slrd_n/     FX2 strobes (active-low)
//   fx2_sloe_n/pktend_n
//   fx2_a                         FIFOADR: 00 = EP2, 10 = EP6
//   fx2_db                        bidirectional data bus
//   fx2_flaga..d                  EP2 !empty, EP6 !full, EP2 full, EP6 empty
//   host_wr_*                     host->EP2 valid/ready stream
//   host_rd_*                     EP6->host valid/ready stream with last
//   err_overflow/underflow/       sticky error flags
//   err_contention
module fx2_slave_fifo_model #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fx2_slcs_n,
  input  logic        fx2_slwr_n,
  input  logic        fx2_slrd_n,
  input  logic        fx2_sloe_n,
  input  logic        fx2_pktend_n,
  input  logic [1:0]  fx2_a,
  inout  wire  [15:0] fx2_db,
  output logic        fx2_flaga,
  output logic        fx2_flagb,
  output logic        fx2_flagc,
  output logic        fx2_flagd,
  input  logic        host_wr_valid,
  input  logic [15:0] host_wr_data,
  output logic        host_wr_ready,
  output logic        host_rd_valid,
  output logic [15:0] host_rd_data,
  output logic        host_rd_last,
  input  logic        host_rd_ready,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic        err_contention
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   r_ep2_mem [DEPTH];
  logic [16:0]   r_ep6_mem [DEPTH];   // {last, data}
  logic [AW-1:0] r_ep2_wp, r_ep2_rp, r_ep6_wp, r_ep6_rp;
  logic [CW-1:0] r_ep2_cnt, r_ep6_cnt;

  logic w_sel_ep2, w_sel_ep6;
  logic w_ep2_empty, w_ep2_full, w_ep6_empty, w_ep6_full;
  logic w_ep2_push, w_ep2_rd, w_ep2_pop;
  logic w_ep6_wr, w_ep6_push, w_ep6_pop, w_ep6_tag, w_contention;
  logic [16:0] w_ep6_head;
  logic [3:0]  w_flags;             // {d, c, b, a}

  // Decode and handshake qualification
  assign w_sel_ep2    = !fx2_slcs_n && (fx2_a == 2'b00);
  assign w_sel_ep6    = !fx2_slcs_n && (fx2_a == 2'b10);
  assign w_ep2_empty  = (r_ep2_cnt == '0);
  assign w_ep2_full   = (r_ep2_cnt == FULL_CNT);
  assign w_ep6_empty  = (r_ep6_cnt == '0);
  assign w_ep6_full   = (r_ep6_cnt == FULL_CNT);
  assign w_ep2_push   = host_wr_valid && !w_ep2_full;
  assign w_ep2_rd     = w_sel_ep2 && !fx2_slrd_n;
  assign w_ep2_pop    = w_ep2_rd && !w_ep2_empty;
  assign w_ep6_pop    = !w_ep6_empty && host_rd_ready;
  assign w_ep6_wr     = w_sel_ep6 && !fx2_slwr_n;
  // A full EP6 still takes a write when the host frees a slot in the same cycle
  assign w_ep6_push   = w_ep6_wr && (!w_ep6_full || w_ep6_pop);
  // Retag the newest stored word only when no word is pushed this cycle
  assign w_ep6_tag    = w_sel_ep6 && !fx2_pktend_n && !w_ep6_push && !w_ep6_empty;
  assign w_contention = w_sel_ep2 && !fx2_sloe_n && !fx2_slwr_n;

  // EP2 head onto the bus, zero latency from the strobes
  assign fx2_db = (w_sel_ep2 && !fx2_sloe_n)
                ? (w_ep2_empty ? IDLE_WORD : r_ep2_mem[r_ep2_rp])
                : 16'hzzzz;

  // EP6 head to host; reads as zero while empty
  assign w_ep6_head    = r_ep6_mem[r_ep6_rp];
  assign host_rd_valid = !w_ep6_empty;
  assign host_rd_data  = w_ep6_empty ? 16'h0000 : w_ep6_head[15:0];
  assign host_rd_last  = !w_ep6_empty && w_ep6_head[16];
  assign host_wr_ready = !w_ep2_full;

  // Storage arrays; contents are discarded by resetting pointers and counts
  always_ff @(posedge clk) begin
    if (w_ep2_push) r_ep2_mem[r_ep2_wp] <= host_wr_data;
    if (w_ep6_push) r_ep6_mem[r_ep6_wp] <= {!fx2_pktend_n, fx2_db};
    else if (w_ep6_tag) r_ep6_mem[r_ep6_wp - AW'(1)][16] <= 1'b1;
  end

  // Pointers, occupancy and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ep2_wp       <= '0;
      r_ep2_rp       <= '0;
      r_ep2_cnt      <= '0;
      r_ep6_wp       <= '0;
      r_ep6_rp       <= '0;
      r_ep6_cnt      <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      if (w_ep2_push) r_ep2_wp <= r_ep2_wp + AW'(1);
      if (w_ep2_pop)  r_ep2_rp <= r_ep2_rp + AW'(1);
      r_ep2_cnt <= r_ep2_cnt + CW'(w_ep2_push) - CW'(w_ep2_pop);
      if (w_ep6_push) r_ep6_wp <= r_ep6_wp + AW'(1);
      if (w_ep6_pop)  r_ep6_rp <= r_ep6_rp + AW'(1);
      r_ep6_cnt <= r_ep6_cnt + CW'(w_ep6_push) - CW'(w_ep6_pop);
      if (w_ep6_wr && !w_ep6_push) err_overflow   <= 1'b1;
      if (w_ep2_rd && w_ep2_empty) err_underflow  <= 1'b1;
      if (w_contention)            err_contention <= 1'b1;
    end
  end

  assign w_flags = {w_ep6_empty, w_ep2_full, !w_ep6_full, !w_ep2_empty};

`ifdef FX2_MODEL_FLAG_LATENCY_EN
  logic [3:0] r_flags;

  // Extra flag stage: the master sees each change one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flags <= 4'b1010;
    else        r_flags <= w_flags;
  end

  assign {fx2_flagd, fx2_flagc, fx2_flagb, fx2_flaga} = r_flags;
`else
  assign {fx2_flagd, fx2_flagc, fx2_flagb, fx2_flaga} = w_flags;
`endif

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
module tb_fx2_slave_fifo_model;

  localparam logic [15:0] IDLE = 16'hBEEF;
`ifdef FX2_MODEL_FLAG_LATENCY_EN
  localparam bit LAT = 1'b1;
`else
  localparam bit LAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slcs_n, slwr_n, slrd_n, sloe_n, pktend_n;
  logic [1:0]  a;
  wire  [15:0] db;
  logic        drv_en;
  logic [15:0] drv_val;
  logic        flaga, flagb, flagc, flagd;
  logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
  logic [15:0] wr_data, rd_data;
  logic        e_ovf, e_unf, e_con;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_db[$];
  logic [16:0] exp_host[$];

  assign db = drv_en ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  fx2_slave_fifo_model #(.DEPTH_LOG2(8), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .fx2_slcs_n(slcs_n), .fx2_slwr_n(slwr_n), .fx2_slrd_n(slrd_n),
    .fx2_sloe_n(sloe_n), .fx2_pktend_n(pktend_n), .fx2_a(a), .fx2_db(db),
    .fx2_flaga(flaga), .fx2_flagb(flagb), .fx2_flagc(flagc), .fx2_flagd(flagd),
    .host_wr_valid(wr_valid), .host_wr_data(wr_data), .host_wr_ready(wr_ready),
    .host_rd_valid(rd_valid), .host_rd_data(rd_data), .host_rd_last(rd_last),
    .host_rd_ready(rd_ready),
    .err_overflow(e_ovf), .err_underflow(e_unf), .err_contention(e_con)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every EP2 read beat and every host handshake pops the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (!slcs_n && a == 2'b00 && !sloe_n && !slrd_n) begin
        if (exp_db.size() == 0) begin
          checks++; errors++;
          $display("FAIL ep2_read_unexpected actual=%h required=none", db);
        end else check("ep2_read", 32'(db), 32'(exp_db.pop_front()));
      end
      if (rd_valid && rd_ready) begin
        if (exp_host.size() == 0) begin
          checks++; errors++;
          $display("FAIL host_rd_unexpected actual=%h required=none", {rd_last, rd_data});
        end else check("host_rd", 32'({rd_last, rd_data}), 32'(exp_host.pop_front()));
      end
    end
  end

  task automatic drain_host(input int budget);
    int k;
    rd_ready = 1'b1;
    for (k = 0; k < budget && exp_host.size() != 0; k++) tick;
    check("host_drain_timeout", 32'(exp_host.size()), 32'd0);
    exp_host.delete();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; slcs_n = 1'b1; slwr_n = 1'b1; slrd_n = 1'b1; sloe_n = 1'b1;
    pktend_n = 1'b1; a = 2'b11; drv_en = 1'b0; drv_val = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;

    // Reset state
    check("rst_flags_dcba", 32'({flagd, flagc, flagb, flaga}), 32'b1010);
    check("rst_errors", 32'({e_ovf, e_unf, e_con}), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_host_rd", 32'({rd_valid, rd_last, rd_data}), 32'd0);
    drv_en = 1'b1; drv_val = 16'hA5A5; #1;
    check("rst_bus_not_driven", 32'(db), 32'hA5A5);
    drv_en = 1'b0;

    // Two host pushes into EP2, then FWFT reads
    wr_valid = 1'b1; wr_data = 16'h1234; tick;
    check("flaga_after_push1", 32'(flaga), LAT ? 32'd0 : 32'd1);
    wr_data = 16'h5678; tick;
    wr_valid = 1'b0;
    check("flaga_after_push2", 32'(flaga), 32'd1);
    slcs_n = 1'b0; a = 2'b00; sloe_n = 1'b0; tick;
    check("ep2_head_fwft", 32'(db), 32'h1234);
    exp_db.push_back(16'h1234); exp_db.push_back(16'h5678);
    slrd_n = 1'b0; tick; tick;
    slrd_n = 1'b1;
    check("flaga_fall_edge", 32'(flaga), LAT ? 32'd1 : 32'd0);
    tick;
    check("flaga_fall_settled", 32'(flaga), 32'd0);

    // Fill EP2 to full, then read it all back
    sloe_n = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin wr_data = 16'(i * 3); tick; end
    wr_valid = 1'b0; tick;
    check("ep2_full_flagc", 32'({flagc, flaga, wr_ready}), 32'b110);
    for (int i = 0; i < 256; i++) exp_db.push_back(16'(i * 3));
    sloe_n = 1'b0; slrd_n = 1'b0;
    repeat (256) tick;
    slrd_n = 1'b1; repeat (2) tick;
    check("ep2_drained_flags", 32'({flagc, flaga, wr_ready}), 32'b001);
    check("no_underflow_yet", 32'(e_unf), 32'd0);

    // Read of an empty EP2
    check("ep2_idle_word", 32'(db), 32'(IDLE));
    exp_db.push_back(IDLE);
    slrd_n = 1'b0; tick;
    slrd_n = 1'b1;
    check("underflow_set", 32'(e_unf), 32'd1);
    sloe_n = 1'b1;

    // Eight EP6 words, pktend with the last
    a = 2'b10; drv_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drv_val = 16'(i); slwr_n = 1'b0; pktend_n = (i == 8) ? 1'b0 : 1'b1;
      exp_host.push_back({(i == 8), 16'(i)});
      tick;
    end
    slwr_n = 1'b1; pktend_n = 1'b1; repeat (2) tick;
    check("ep6_flagd_busy", 32'(flagd), 32'd0);
    drain_host(50);

    // Fill EP6 with no host drain, overflow on the 257th
    for (int i = 0; i < 256; i++) begin
      drv_val = 16'hA000 + 16'(i); slwr_n = 1'b0;
      exp_host.push_back({1'b0, 16'hA000 + 16'(i)});
      tick;
    end
    slwr_n = 1'b1; repeat (2) tick;
    check("ep6_full_flags_bd", 32'({flagb, flagd}), 32'b00);
    check("ep6_no_overflow_yet", 32'(e_ovf), 32'd0);
    check("ep6_head_visible", 32'({rd_valid, rd_data}), 32'h1A000);
    drv_val = 16'hDEAD; slwr_n = 1'b0; tick;
    slwr_n = 1'b1;
    check("overflow_set", 32'(e_ovf), 32'd1);
    drain_host(400);
    repeat (2) tick;
    check("ep6_empty_flags_bd", 32'({flagb, flagd}), 32'b11);

    // Contention: read-enable and write strobe on EP2 together
    drv_en = 1'b0; a = 2'b00; sloe_n = 1'b0; slwr_n = 1'b0; tick;
    slwr_n = 1'b1; sloe_n = 1'b1; repeat (2) tick;
    check("contention_set", 32'(e_con), 32'd1);
    check("contention_ep6_untouched", 32'({rd_valid, flagd}), 32'b01);

    // Reset mid-transfer clears EP6 immediately
    a = 2'b10; drv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin drv_val = 16'h7700 + 16'(i); slwr_n = 1'b0; tick; end
    slwr_n = 1'b1; tick;
    check("pre_reset_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    check("async_reset_clear", 32'({rd_valid, flagd, flagb, e_ovf, e_con}), 32'b01100);
    tick; rst_n = 1'b1; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
